apu_length_counter_bank: RTL
============================

APU_LENGTH_COUNTER_BANK -- requirements
Module: apu_length_counter_bank

Interface
REQ-001 SHALL provide parameter NUM_CH, default 4, number of independent length-counter channels (legal 1..8).
REQ-002 SHALL provide parameter CNT_W, default 8, counter width per channel (legal 8..16).
REQ-003 SHALL provide parameter CH_W, default 2, channel-select width, equal to max(1, ceil(log2(NUM_CH))).
REQ-004 SHALL provide port clk  input  1  system clock, all state updates on rising edge.
REQ-005 SHALL provide port rst_l  input  1  reset, asynchronous, active-low.
REQ-006 SHALL provide port cpu_clk_en  input  1  CPU-cycle qualifier for register writes.
REQ-007 SHALL provide port half_clk_en  input  1  half-frame tick from the frame sequencer.
REQ-008 SHALL provide port load  input  1  length-load write strobe, qualified by cpu_clk_en.
REQ-009 SHALL provide port load_ch  input  CH_W  channel targeted by load.
REQ-010 SHALL provide port load_idx  input  5  length table index.
REQ-011 SHALL provide port halt  input  NUM_CH  per-channel halt flag.
REQ-012 SHALL provide port enable  input  NUM_CH  per-channel enable mask (status-register bits).
REQ-013 SHALL provide port non_zero  output  NUM_CH  per-channel count-not-zero flag.
REQ-014 SHALL provide port count_o  output  NUM_CH*CNT_W  flattened counts, channel i at bits [i*CNT_W +: CNT_W].
REQ-015 SHALL provide port any_non_zero  output  1  OR of all non_zero bits.

Function
REQ-016 Each channel SHALL hold count (CNT_W), pending (1) and idx (5) registers, independent of the other channels.
REQ-017 A write occurs for channel i when cpu_clk_en & load & load_ch==i & enable[i]. load_ch >= NUM_CH SHALL be ignored.
REQ-018 On a write without half_clk_en in the same cycle, the channel SHALL set pending=1 and idx=load_idx. A later write before the next tick SHALL overwrite idx.
REQ-019 On half_clk_en with pending=1 and no same-cycle write, the channel SHALL set count=LUT(idx) and pending=0, regardless of halt.
REQ-020 On half_clk_en with a same-cycle write, the channel SHALL set count=LUT(load_idx) and pending=0, ignoring any previous idx.
REQ-021 On half_clk_en with pending=0, no write, halt[i]=0 and count!=0, the channel SHALL decrement count by 1. It SHALL never wrap below 0.
REQ-022 On half_clk_en with halt[i]=1 and no reload, the channel SHALL hold count.
REQ-023 While enable[i]=0, the channel SHALL force count=0 and pending=0 on every clk edge, with no qualifier. Writes SHALL be dropped. This has priority over all other updates.
REQ-024 LUT SHALL be the 32-entry NES table, indices 0..31: 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30. Values SHALL be zero-extended to CNT_W.
REQ-025 Without cpu_clk_en or half_clk_en, no state SHALL change except under REQ-023.
REQ-026 non_zero[i] SHALL equal (count!=0) combinationally from the count register. It SHALL not reflect pending.
REQ-027 count_o and any_non_zero SHALL be direct combinational functions of the count registers, with zero added latency.

Reset
REQ-028 rst_l low SHALL asynchronously clear every count, pending and idx to 0.
REQ-029 While rst_l is low, non_zero, count_o and any_non_zero SHALL all be 0.
REQ-030 Reset asserted mid-operation SHALL discard pending reloads. The first tick after release SHALL see the cleared state.

Verification
REQ-031 Scenario: NUM_CH=4, enable=4'hF, write ch2 idx=1, then one tick -> count_o ch2=254, non_zero=4'b0100; after 3 more ticks ch2=251.
REQ-032 Scenario: write ch0 idx=3 with halt[0]=1, tick, then 5 ticks -> ch0=2 after the first tick and held at 2; release halt, 2 ticks -> ch0=0, non_zero[0]=0, stays 0 on further ticks.
REQ-033 Scenario: write ch1 idx=0, then write ch1 idx=8 before the tick -> tick loads 160, not 10. A write of idx=5 coinciding with a tick -> count=4 that cycle.
REQ-034 Scenario: ch3 count=60 and enable[3] drops with no tick -> ch3=0 next edge. A write to ch3 while disabled followed by a tick -> ch3 remains 0.
REQ-035 Scenario: ch1 pending idx=24, assert rst_l low for 1 cycle mid-frame -> all outputs 0. The next tick leaves ch1=0, and any_non_zero=0.
REQ-036 Scenario: NUM_CH=3, write with load_ch=3 -> no channel changes. CNT_W=12 idx=24 -> count_o field = 12'd192.

Source files
------------

// File: rtl/apu_length_counter_bank.sv
// apu_length_counter_bank
//   A bank of independent length counters. Each channel owns a down-counter,
//   a pending-reload flag and a latched table index. A CPU write arms a
//   reload. The reload is applied on the next half-frame tick, or on the
//   same tick if the write and the tick coincide. Otherwise each tick
//   decrements the count unless the channel is halted.
//
// Ports
//   clk           system clock, rising edge
//   rst_l         asynchronous active-low reset
//   cpu_clk_en    qualifies load writes
//   half_clk_en   half-frame tick from the frame sequencer
//   load          length-load write strobe
//   load_ch       channel targeted by load; values >= NUM_CH are ignored
//   load_idx      length table index (0..31)
//   halt          per-channel halt flag
//   enable        per-channel enable mask; a low bit clears that channel
//   non_zero      per-channel (count != 0)
//   count_o       flattened counts, channel i at [i*CNT_W +: CNT_W]
//   any_non_zero  OR of non_zero
module apu_length_counter_bank #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8,
    parameter int CH_W   = 2
) (
    input  logic                    clk,
    input  logic                    rst_l,
    input  logic                    cpu_clk_en,
    input  logic                    half_clk_en,
    input  logic                    load,
    input  logic [CH_W-1:0]         load_ch,
    input  logic [4:0]              load_idx,
    input  logic [NUM_CH-1:0]       halt,
    input  logic [NUM_CH-1:0]       enable,
    output logic [NUM_CH-1:0]       non_zero,
    output logic [NUM_CH*CNT_W-1:0] count_o,
    output logic                    any_non_zero
);

    function automatic logic [7:0] length_lut(input logic [4:0] idx);
        logic [7:0] val;
        case (idx)
            5'd0:  val = 8'd10;   5'd1:  val = 8'd254;
            5'd2:  val = 8'd20;   5'd3:  val = 8'd2;
            5'd4:  val = 8'd40;   5'd5:  val = 8'd4;
            5'd6:  val = 8'd80;   5'd7:  val = 8'd6;
            5'd8:  val = 8'd160;  5'd9:  val = 8'd8;
            5'd10: val = 8'd60;   5'd11: val = 8'd10;
            5'd12: val = 8'd14;   5'd13: val = 8'd12;
            5'd14: val = 8'd26;   5'd15: val = 8'd14;
            5'd16: val = 8'd12;   5'd17: val = 8'd16;
            5'd18: val = 8'd24;   5'd19: val = 8'd18;
            5'd20: val = 8'd48;   5'd21: val = 8'd20;
            5'd22: val = 8'd96;   5'd23: val = 8'd22;
            5'd24: val = 8'd192;  5'd25: val = 8'd24;
            5'd26: val = 8'd72;   5'd27: val = 8'd26;
            5'd28: val = 8'd16;   5'd29: val = 8'd28;
            5'd30: val = 8'd32;   default: val = 8'd30;
        endcase
        return val;
    endfunction

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] count;
        logic             pending;
        logic [4:0]       idx;
        logic             wr;

        // load_ch values beyond the last channel never match any i.
        assign wr = cpu_clk_en & load & (load_ch == CH_W'(i)) & enable[i];

        always_ff @(posedge clk or negedge rst_l) begin
            if (!rst_l) begin
                count   <= '0;
                pending <= 1'b0;
                idx     <= '0;
            end else if (!enable[i]) begin
                // Disabled channels are held cleared every edge, unqualified.
                count   <= '0;
                pending <= 1'b0;
            end else if (wr && half_clk_en) begin
                count   <= CNT_W'(length_lut(load_idx));
                pending <= 1'b0;
                idx     <= load_idx;
            end else if (wr) begin
                pending <= 1'b1;
                idx     <= load_idx;
            end else if (half_clk_en) begin
                if (pending) begin
                    // Reload ignores halt.
                    count   <= CNT_W'(length_lut(idx));
                    pending <= 1'b0;
                end else if (!halt[i] && count != '0) begin
                    count <= count - 1'b1;
                end
            end
        end

        assign non_zero[i]              = (count != '0);
        assign count_o[i*CNT_W +: CNT_W] = count;
    end

    assign any_non_zero = |non_zero;

endmodule
